junction_phase_sched: RTL and testbench



---
 rtl/junction_phase_sched.sv | 148 ++++++++++++++
 tb/tb_junction_phase_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/junction_phase_sched.sv
//==============================================================================
// junction_phase_sched : four-approach junction phase scheduler, main road
// resting in green, round-robin side approaches, all-red pedestrian walk.
// Revision: 1.0
//==============================================================================
`default_nettype none

module junction_phase_sched #(
   parameter int MIN_G     = 5,
   parameter int MAX_G     = 20,
   parameter int Y_TIME    = 3,
   parameter int AR_TIME   = 2,
   parameter int WALK_TIME = 8
) (
   input  logic       clock,
   input  logic       clear,
   input  logic [3:0] car_req,
   input  logic       ped_req,
   output logic [7:0] sig_out,
   output logic       walk,
   output logic [1:0] phase_id,
   output logic       ped_wait
);

   localparam logic [1:0] S_GREEN   = 2'd0;
   localparam logic [1:0] S_YELLOW  = 2'd1;
   localparam logic [1:0] S_ALL_RED = 2'd2;
   localparam logic [1:0] S_WALK    = 2'd3;

   localparam logic [1:0] LAMP_YELLOW = 2'd1;
   localparam logic [1:0] LAMP_GREEN  = 2'd2;

   localparam logic [7:0] MIN_G_LAST  = 8'(MIN_G - 1);
   localparam logic [7:0] MAX_G_LAST  = 8'(MAX_G - 1);
   localparam logic [7:0] Y_LAST      = 8'(Y_TIME - 1);
   localparam logic [7:0] AR_LAST     = 8'(AR_TIME - 1);
   localparam logic [7:0] WALK_LAST   = 8'(WALK_TIME - 1);

   logic [1:0] state, state_nxt;
   logic [1:0] owner, owner_nxt;
   logic [1:0] last_side, last_side_nxt;
   logic       from_main, from_main_nxt;
   logic       after_walk, after_walk_nxt;
   logic [7:0] cnt;
   logic       ped_pend;

   logic       side_found;
   logic [1:0] side_pick;
   logic [1:0] cand;

   // Round-robin over sides 1..3 starting after last_side; last_side itself
   // is tried last so a lone requester is never starved.
   always_comb begin
      side_found = 1'b0;
      side_pick  = 2'd0;
      cand       = last_side;
      for (int i = 0; i < 4; i++) begin
         cand = cand + 2'd1;
         if (!side_found && cand != 2'd0 && car_req[cand]) begin
            side_found = 1'b1;
            side_pick  = cand;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= S_GREEN;
         owner      <= 2'd0;
         last_side  <= 2'd3;
         from_main  <= 1'b1;
         after_walk <= 1'b0;
         cnt        <= 8'd0;
         ped_pend   <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_side  <= last_side_nxt;
         from_main  <= from_main_nxt;
         after_walk <= after_walk_nxt;
         if (state_nxt != state)
            cnt <= 8'd0;
         else if (cnt != 8'hFF)
            cnt <= cnt + 8'd1;
         // A press on the WALK entry edge stays pending for a later walk.
         ped_pend <= ped_req | (ped_pend & ~(state_nxt == S_WALK && state != S_WALK));
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_side_nxt  = last_side;
      from_main_nxt  = from_main;
      after_walk_nxt = after_walk;
      case (state)
         S_GREEN: begin
            if (owner == 2'd0) begin
               if (cnt >= MIN_G_LAST && ((|car_req[3:1]) || ped_pend))
                  state_nxt = S_YELLOW;
            end else if ((cnt >= MIN_G_LAST && !car_req[owner]) || cnt == MAX_G_LAST) begin
               state_nxt = S_YELLOW;
            end
         end
         S_YELLOW: begin
            if (cnt == Y_LAST) begin
               state_nxt      = S_ALL_RED;
               from_main_nxt  = (owner == 2'd0);
               after_walk_nxt = 1'b0;
            end
         end
         S_ALL_RED: begin
            if (cnt == AR_LAST) begin
               if (ped_pend && !after_walk) begin
                  state_nxt = S_WALK;
               end else if (from_main && side_found) begin
                  state_nxt     = S_GREEN;
                  owner_nxt     = side_pick;
                  last_side_nxt = side_pick;
               end else begin
                  state_nxt = S_GREEN;
                  owner_nxt = 2'd0;
               end
            end
         end
         default: begin
            if (cnt == WALK_LAST) begin
               state_nxt      = S_ALL_RED;
               after_walk_nxt = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      sig_out = 8'h00;
      if (state == S_GREEN)
         sig_out[{owner, 1'b0} +: 2] = LAMP_GREEN;
      else if (state == S_YELLOW)
         sig_out[{owner, 1'b0} +: 2] = LAMP_YELLOW;
      walk     = (state == S_WALK);
      phase_id = owner;
      ped_wait = ped_pend;
   end

endmodule

`default_nettype wire

// File: tb/tb_junction_phase_sched.sv
//==============================================================================
// tb_junction_phase_sched : directed and random stimulus against a timed-phase
// reference model of the junction. Revision: 1.0
//==============================================================================
`default_nettype none

module tb_junction_phase_sched;

   localparam int MIN_G     = 5;
   localparam int MAX_G     = 20;
   localparam int Y_TIME    = 3;
   localparam int AR_TIME   = 2;
   localparam int WALK_TIME = 8;

   logic       clock = 1'b0;
   logic       clear;
   logic [3:0] car_req;
   logic       ped_req;
   logic [7:0] sig_out;
   logic       walk;
   logic [1:0] phase_id;
   logic       ped_wait;

   junction_phase_sched #(
      .MIN_G(MIN_G), .MAX_G(MAX_G), .Y_TIME(Y_TIME),
      .AR_TIME(AR_TIME), .WALK_TIME(WALK_TIME)
   ) dut (
      .clock(clock), .clear(clear), .car_req(car_req), .ped_req(ped_req),
      .sig_out(sig_out), .walk(walk), .phase_id(phase_id), .ped_wait(ped_wait)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase kind, who holds it and how many cycles shown.
   // kind: 0 green, 1 yellow, 2 all-red, 3 walk
   bit m_valid = 0;
   int m_kind, m_owner, m_last, m_shown;
   bit m_from_main, m_came_from_walk, m_ped;

   task automatic model_step(input bit clr, input logic [3:0] car, input bit ped);
      int  nk;
      int  side;
      bit  into_walk;
      if (clr) begin
         m_valid = 1; m_kind = 0; m_owner = 0; m_last = 3; m_shown = 1;
         m_from_main = 1; m_came_from_walk = 0; m_ped = 0;
         return;
      end
      nk = m_kind;
      case (m_kind)
         0: begin
            if (m_owner == 0) begin
               if (m_shown >= MIN_G && (car[3:1] != 3'b000 || m_ped)) nk = 1;
            end else if ((m_shown >= MIN_G && !car[m_owner]) || m_shown >= MAX_G) begin
               nk = 1;
            end
         end
         1: if (m_shown == Y_TIME) begin
               nk = 2; m_from_main = (m_owner == 0); m_came_from_walk = 0;
            end
         2: if (m_shown == AR_TIME) begin
               if (m_ped && !m_came_from_walk) nk = 3;
               else begin
                  side = 0;
                  if (m_from_main)
                     for (int k = 1; k <= 3; k++) begin
                        int s = ((m_last - 1 + k) % 3) + 1;
                        if (side == 0 && car[s]) side = s;
                     end
                  nk = 0;
                  m_owner = side;
                  if (side != 0) m_last = side;
               end
            end
         default: if (m_shown == WALK_TIME) begin
               nk = 2; m_came_from_walk = 1;
            end
      endcase
      into_walk = (nk == 3 && m_kind != 3);
      m_ped = into_walk ? ped : (m_ped | ped);
      if (nk != m_kind) m_shown = 1;
      else m_shown++;
      m_kind = nk;
   endtask

   task automatic cycle(input bit clr, input logic [3:0] car, input bit ped);
      logic [7:0] exp_sig;
      @(negedge clock);
      if (m_valid) begin
         exp_sig = 8'h00;
         if (m_kind == 0) exp_sig = 8'(2 << (2 * m_owner));
         if (m_kind == 1) exp_sig = 8'(1 << (2 * m_owner));
         check_eq("sig_out",  32'(sig_out),  32'(exp_sig));
         check_eq("walk",     32'(walk),     32'(m_kind == 3));
         check_eq("phase_id", 32'(phase_id), 32'(m_owner));
         check_eq("ped_wait", 32'(ped_wait), 32'(m_ped));
      end
      clear   = clr;
      car_req = car;
      ped_req = ped;
      model_step(clr, car, ped);
   endtask

   initial begin
      logic [3:0] rc;
      clear = 1'b1; car_req = 4'h0; ped_req = 1'b0;

      repeat (5)   cycle(1, 4'h0, 0);
      repeat (100) cycle(0, 4'h0, 0);
      // Side 2 held: main yellow, max-length side greens alternating with main.
      repeat (120) cycle(0, 4'b0100, 0);
      repeat (30)  cycle(0, 4'h0, 0);
      // Brief side-1 request during main rest.
      repeat (3)   cycle(0, 4'b0010, 0);
      repeat (40)  cycle(0, 4'h0, 0);
      // All sides held: round-robin interleaved with main.
      repeat (200) cycle(0, 4'b1110, 0);
      repeat (30)  cycle(0, 4'h0, 0);
      // Pedestrian pulse, then a second pulse while walking.
      cycle(0, 4'h0, 1);
      repeat (12)  cycle(0, 4'h0, 0);
      cycle(0, 4'h0, 1);
      repeat (60)  cycle(0, 4'h0, 0);
      // Clear partway through a side-2 green, then sides 1 and 3 requesting.
      repeat (14)  cycle(0, 4'b0100, 0);
      cycle(1, 4'b0100, 0);
      repeat (60)  cycle(0, 4'b1010, 0);
      repeat (20)  cycle(0, 4'h0, 0);

      rc = 4'h0;
      for (int n = 0; n < 6000; n++) begin
         for (int b = 1; b < 4; b++)
            if ($urandom_range(0, 24) == 0) rc[b] = ~rc[b];
         rc[0] = 1'($urandom_range(0, 1));
         cycle(($urandom_range(0, 699) == 0), rc, ($urandom_range(0, 79) == 0));
      end
      cycle(0, 4'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
